// File: rtl/bcd_countdown_mod6_pkg.sv
// Shared timer package: BCD digit type and the wrap limits used by the
// mod-6 and mod-10 digit counters of the timer chain.
package bcd_countdown_mod6_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t MOD6_MAX  = 4'd5;
    localparam bcd_digit_t MOD10_MAX = 4'd9;

    // Out-of-range load values clamp to the digit's top value.
    function automatic bcd_digit_t bcd_saturate(input bcd_digit_t value,
                                                input bcd_digit_t max_val);
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/bcd_countdown_mod6_if.sv
// Control and status bundle of one timer digit; the master drives load/enable,
// the slave (the counter) returns the count and its flags.
interface bcd_countdown_mod6_if;
    import bcd_countdown_mod6_pkg::*;

    logic       loadn;
    logic       en;
    bcd_digit_t data;
    bcd_digit_t out;
    logic       tc;
    logic       zero;

    modport master (
        output loadn,
        output en,
        output data,
        input  out,
        input  tc,
        input  zero
    );

    modport slave (
        input  loadn,
        input  en,
        input  data,
        output out,
        output tc,
        output zero
    );

endinterface

// File: rtl/bcd_countdown_mod6.sv
// Tens-of-seconds digit of the microwave timer: BCD down counter 5..0 with
// synchronous clear/load; tc borrows into the minutes digit.
module bcd_countdown_mod6
    import bcd_countdown_mod6_pkg::*;
(
    input  logic                      clk,
    input  logic                      clr,
    bcd_countdown_mod6_if.slave       bus
);

    localparam bcd_digit_t MAX_VAL = MOD6_MAX;

    bcd_digit_t count_q;
    bcd_digit_t count_d;

    // Priority: clear, then load, then decrement with wrap, else hold.
    always_comb begin
        count_d = count_q;
        if (!bus.loadn) begin
            count_d = bcd_saturate(bus.data, MAX_VAL);
        end else if (bus.en) begin
            count_d = (count_q == 4'd0) ? MAX_VAL : count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.out  = count_q;
    assign bus.zero = (count_q == 4'd0);
    assign bus.tc   = bus.en && (count_q == 4'd0);

endmodule

// File: tb/tb_bcd_countdown_mod6.sv
// Directed bench for the mod-6 BCD down counter: reset, load, count, wrap,
// control priority and out-of-range load saturation.
module tb_bcd_countdown_mod6;

    logic clk;
    logic clr;
    int   checkCount;
    int   errorCount;

    bcd_countdown_mod6_if bus ();

    bcd_countdown_mod6 dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; results are sampled there too.
    task automatic applyStimulus(input logic c, input logic l, input logic e,
                                 input logic [3:0] d);
        clr       = c;
        bus.loadn = l;
        bus.en    = e;
        bus.data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] actual,
                               input logic [3:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] expOut,
                            input logic expZero, input logic expTc);
        checkOutput({tag, ".out"},  bus.out,         expOut);
        checkOutput({tag, ".zero"}, {3'b0, bus.zero}, {3'b0, expZero});
        checkOutput({tag, ".tc"},   {3'b0, bus.tc},   {3'b0, expTc});
    endtask

    logic [3:0] wrapSeq [10] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0,
                                 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

    initial begin
        checkCount = 0;
        errorCount = 0;
        clr       = 1'b1;
        bus.loadn = 1'b1;
        bus.en    = 1'b0;
        bus.data  = 4'd0;

        // Reset
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkAll("reset", 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd3);
        checkAll("reset_en", 4'd0, 1'b1, 1'b1);

        // Load 4, count down twice with junk on data, then hold
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd4);
        checkAll("load4", 4'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'hF);
        checkAll("dec1", 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'hA);
        checkAll("dec2", 4'd2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'hF);
        checkAll("hold", 4'd2, 1'b0, 1'b0);

        // Mid-operation clear
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkAll("clr_mid", 4'd0, 1'b1, 1'b0);

        // Full wrap from 5
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd5);
        checkAll("load5", 4'd5, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
            checkAll($sformatf("wrap%0d", i), wrapSeq[i],
                     wrapSeq[i] == 4'd0, wrapSeq[i] == 4'd0);
        end

        // Priority: load beats enable, clear beats everything
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd3);
        checkAll("load3", 4'd3, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd1);
        checkAll("load_over_en", 4'd1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd4);
        checkAll("clr_over_load", 4'd0, 1'b1, 1'b1);

        // At zero with enable low there is no borrow
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
        checkAll("zero_no_en", 4'd0, 1'b1, 1'b0);

        // Out-of-range loads saturate to 5
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd9);
        checkAll("load9", 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        checkAll("dec_after9", 4'd4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd15);
        checkAll("load15", 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd6);
        checkAll("load6", 4'd5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0);
        checkAll("load0_en", 4'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        checkAll("wrap_after_load0", 4'd5, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
